ex1_jk_ff: RTL and testbench



---
 rtl/jk_pkg.sv | 27 ++
 rtl/ex1_jk_bit.sv | 24 ++
 rtl/ex1_jk_ff.sv | 26 ++
 tb/tb_ex1_jk_ff.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared JK definitions: command encodings and the next-state rule used by every bit.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_cmd_e;

    localparam logic Q_CLEAR  = 1'b0;
    localparam logic Q_PRESET = 1'b1;

    // An unknown q stays unknown through a toggle; only CLR gives a defined start.
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic nxt;
        case ({j, k})
            JK_HOLD: nxt = q;
            JK_RST:  nxt = 1'b0;
            JK_SET:  nxt = 1'b1;
            JK_TGL:  nxt = ~q;
            default: nxt = 1'bx;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ex1_jk_bit.sv
// Single-bit JK flip-flop, rising-edge CK, async active-low clear and preset (clear wins).
module ex1_jk_bit
    import jk_pkg::*;
(
    input  logic J,
    input  logic K,
    input  logic CK,
    input  logic PR,
    input  logic CLR,
    output logic Q
);

    // Forced values hold after release until the next CK edge applies the JK rule.
    always_ff @(posedge CK or negedge CLR or negedge PR) begin
        if (!CLR) begin
            Q <= Q_CLEAR;
        end else if (!PR) begin
            Q <= Q_PRESET;
        end else begin
            Q <= jk_next(Q, J, K);
        end
    end

endmodule

// File: rtl/ex1_jk_ff.sv
// Bank of WIDTH independent JK flip-flops sharing CK, PR and CLR.
module ex1_jk_ff
    import jk_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             CK,
    input  logic             PR,
    input  logic             CLR,
    output logic [WIDTH-1:0] Q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ex1_jk_bit u_bit (
            .J   (J[i]),
            .K   (K[i]),
            .CK  (CK),
            .PR  (PR),
            .CLR (CLR),
            .Q   (Q[i])
        );
    end

endmodule

// File: tb/tb_ex1_jk_ff.sv
// Directed plus random checks of 1-bit and 4-bit JK banks against a bench-side model.
module tb_ex1_jk_ff;

    logic       CK;
    logic       PR;
    logic       CLR;
    logic       J1, K1, Q1;
    logic [3:0] J4, K4, Q4;

    logic       m1;
    logic [3:0] m4;
    logic [4:0] exp_q[$];
    int         checks;
    int         failures;

    ex1_jk_ff #(.WIDTH(1)) u_dut1 (
        .J(J1), .K(K1), .CK(CK), .PR(PR), .CLR(CLR), .Q(Q1)
    );

    ex1_jk_ff #(.WIDTH(4)) u_dut4 (
        .J(J4), .K(K4), .CK(CK), .PR(PR), .CLR(CLR), .Q(Q4)
    );

    // 20 ns clock, rising edges at 10, 30, 50, ...
    initial CK = 1'b0;
    always #10 CK = ~CK;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic model_next(input logic q, input logic j, input logic k);
        if (j === 1'b0 && k === 1'b0) return q;
        if (j === 1'b0 && k === 1'b1) return 1'b0;
        if (j === 1'b1 && k === 1'b0) return 1'b1;
        if (j === 1'b1 && k === 1'b1) return ~q;
        return 1'bx;
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [4:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            exp = exp_q.pop_front();
            check(tag, {Q4, Q1}, exp);
        end
    endtask

    task automatic apply_async_model();
        if (!CLR) begin
            m1 = 1'b0;
            m4 = 4'h0;
        end else if (!PR) begin
            m1 = 1'b1;
            m4 = 4'hf;
        end
    endtask

    // Drive J/K on the falling edge, predict, then compare just after the rising edge.
    task automatic clk_step(input logic j1, input logic k1,
                            input logic [3:0] j4, input logic [3:0] k4, input string tag);
        @(negedge CK);
        J1 = j1; K1 = k1; J4 = j4; K4 = k4;
        if (!CLR || !PR) begin
            apply_async_model();
        end else begin
            m1 = model_next(m1, j1, k1);
            for (int i = 0; i < 4; i++) m4[i] = model_next(m4[i], j4[i], k4[i]);
        end
        exp_q.push_back({m4, m1});
        @(posedge CK);
        #1;
        pop_check(tag);
    endtask

    // Change CLR/PR away from any edge and compare without waiting for CK.
    task automatic async_set(input logic clr, input logic pr, input string tag);
        CLR = clr;
        PR  = pr;
        apply_async_model();
        exp_q.push_back({m4, m1});
        #1;
        pop_check(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m1       = 1'b0;
        m4       = 4'h0;
        CLR      = 1'b0;
        PR       = 1'b1;
        J1 = 1'bx; K1 = 1'bx; J4 = 4'bx; K4 = 4'bx;
        #1;
        check("reset_q", {Q4, Q1}, 5'b0);

        clk_step(1'bx, 1'bx, 4'bx, 4'bx, "clr_held_edge1");
        clk_step(1'bx, 1'bx, 4'bx, 4'bx, "clr_held_edge2");
        async_set(1'b1, 1'b1, "clr_release_hold");

        clk_step(1'b0, 1'b0, 4'h0, 4'h0, "hold_zero");
        clk_step(1'b0, 1'b1, 4'h0, 4'hf, "reset_cmd");
        clk_step(1'b1, 1'b0, 4'hf, 4'h0, "set_cmd");
        clk_step(1'b1, 1'b1, 4'hf, 4'hf, "toggle_to_0");
        clk_step(1'b1, 1'b1, 4'hf, 4'hf, "toggle_to_1");
        clk_step(1'b0, 1'b1, 4'h0, 4'hf, "reset_before_pr");

        async_set(1'b1, 1'b0, "preset_no_edge");
        clk_step(1'b0, 1'b1, 4'h0, 4'hf, "preset_over_edge");
        async_set(1'b0, 1'b0, "clear_beats_preset");
        async_set(1'b0, 1'b1, "pr_release_still_clr");
        async_set(1'b1, 1'b1, "clr_release_holds_0");

        clk_step(1'b1, 1'b1, 4'hf, 4'hf, "toggle_a");
        clk_step(1'b1, 1'b1, 4'hf, 4'hf, "toggle_b");
        clk_step(1'b1, 1'b1, 4'hf, 4'hf, "toggle_c");
        #5;
        async_set(1'b0, 1'b1, "clr_mid_toggle");
        async_set(1'b1, 1'b1, "clr_mid_release");
        clk_step(1'b1, 1'b1, 4'hf, 4'hf, "toggle_resume");

        clk_step(1'b0, 1'b0, 4'b0011, 4'b1100, "w4_load_0011");
        clk_step(1'b0, 1'b0, 4'b1010, 4'b0110, "w4_mixed");
        check("w4_mixed_const", {Q4, 1'b0}, {4'b1001, 1'b0});

        for (int n = 0; n < 24; n++) begin
            clk_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "random_step");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
